seven_seg_scanner: RTL and testbench

//  Time-multiplexed 7-segment driver. Sits directly downstream of the binary-to-BCD

---
 rtl/seven_seg_scanner.sv | 87 ++++++++
 tb/tb_seven_seg_scanner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 7-segment driver with dead time, per-frame BCD snapshot,
// leading-zero blanking and registered active-low outputs.
module seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        bcd_in [DIGITS],
  input  logic              enable,
  input  logic              lz_blank,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [DIGITS-1:0] an_n,
  output logic              frame_done
);
  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_END = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  typedef enum logic {DEAD, SHOW} state_t;
  localparam state_t START = DEAD_CYCLES == 0 ? SHOW : DEAD;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [3:0]    shadow [DIGITS];
  logic          zero_up, lit, blank;
  logic [6:0]    seg;
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction
  // Current digit and everything above it are zero -> candidate for leading-zero blanking.
  always_comb begin
    zero_up = 1'b1;
    for (int j = 0; j < DIGITS; j++)
      if (j >= int'(idx) && shadow[j] != 4'd0) zero_up = 1'b0;
    lit   = state == SHOW && enable;
    blank = lz_blank && idx != '0 && zero_up;
    seg   = decode(shadow[idx]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= START;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '{default: '0};
      seg_n      <= '1;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= lit ? ~(DIGITS'(1) << idx) : '1;
      seg_n      <= lit && !blank ? seg : '1;
      dp_n       <= !(lit && dp_mask[idx]);
      frame_done <= 1'b0;
      if (state == DEAD) begin
        cnt <= cnt + 1'b1;
        if (cnt == DEAD_END) state <= SHOW;
      end else if (cnt == SLOT_END) begin
        cnt   <= '0;
        state <= START;
        idx   <= idx == LAST_IDX ? '0 : idx + 1'b1;
        if (idx == LAST_IDX) begin
          frame_done <= 1'b1;
          shadow     <= bcd_in;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized and directed checks against a position-in-frame reference model.
module tb_seven_seg_scanner;
  localparam int D = 4, SD = 8, DC = 2, FR = D * SD;
  localparam logic [6:0] PAT [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, lz_blank = 1'b0, frame_done, dp_n;
  logic [3:0] bcd_in [D];
  logic [D-1:0] dp_mask = '0, an_n, e_an;
  logic [6:0] seg_n, e_seg;
  logic e_dp, e_fd;
  logic [3:0] snap [D];
  int p, checks, passed;
  seven_seg_scanner #(.DIGITS(D), .SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .enable(enable), .lz_blank(lz_blank),
    .dp_mask(dp_mask), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done));
  always #5 clk = ~clk;
  task automatic set_bcd(input logic [3:0] d3, d2, d1, d0);
    bcd_in = '{d0, d1, d2, d3};
  endtask
  task automatic model_reset();
    p = 0;
    snap = '{default: 4'd0};
  endtask
  // Pins after edge p+1 reflect the scan position p; snapshot only changes at each frame boundary.
  task automatic step();
    int k, msd;
    logic on;
    k  = (p / SD) % D;
    on = (p % SD) >= DC && enable;
    msd = 0;
    for (int j = 0; j < D; j++) if (snap[j] != 0) msd = j;
    e_an  = on ? ~(D'(1) << k) : '1;
    e_seg = !on ? 7'h7F : (lz_blank && k > msd) ? 7'h7F : PAT[snap[k]];
    e_dp  = !(on && dp_mask[k]);
    @(posedge clk);
    p++;
    e_fd = p % FR == 0;
    if (e_fd) snap = bcd_in;
    #1;
  endtask
  task automatic test_reset();
    checks++;
    if (an_n !== '1 || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL reset an=%b seg=%b dp=%b fd=%b want 1111/1111111/1/0", an_n, seg_n, dp_n, frame_done);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_frames();
    set_bcd(1, 2, 3, 4);
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp || frame_done !== e_fd)
        $display("FAIL frames p=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b", p, an_n, e_an, seg_n, e_seg, dp_n, e_dp, frame_done, e_fd);
      else passed++;
    end
  endtask
  task automatic test_slot_timing();
    int dark, fds;
    dark = 0;
    fds = 0;
    for (int i = 0; i < FR; i++) begin
      step();
      dark += an_n == '1;
      fds += frame_done;
      checks++;
      if ($countones(~an_n) > 1 || an_n !== e_an) $display("FAIL slot_an p=%0d an=%b want %b", p, an_n, e_an);
      else passed++;
    end
    checks++;
    if (dark != D * DC || fds != 1) $display("FAIL slot_counts dark=%0d want %0d fd=%0d want 1", dark, D * DC, fds);
    else passed++;
  endtask
  task automatic test_lz();
    lz_blank = 1'b1;
    set_bcd(0, 0, 7, 0);
    for (int i = 0; i < 2 * FR; i++) begin
      if (i == FR) set_bcd(0, 0, 0, 0);
      step();
      checks++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp || frame_done !== e_fd)
        $display("FAIL lz p=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b", p, an_n, e_an, seg_n, e_seg, dp_n, e_dp, frame_done, e_fd);
      else passed++;
    end
    for (int i = 0; i < FR; i++) begin
      step();
      checks++;
      if (an_n !== e_an || seg_n !== e_seg) $display("FAIL lz_zero p=%0d an=%b/%b seg=%b/%b", p, an_n, e_an, seg_n, e_seg);
      else passed++;
    end
    lz_blank = 1'b0;
  endtask
  task automatic test_snapshot();
    set_bcd(1, 2, 3, 4);
    while (p % FR != 0) step();
    for (int i = 0; i < 3 * FR; i++) begin
      if (i == 12) set_bcd(9, 9, 9, 9);
      if (i == FR + 12) bcd_in[0] = 4'hC;
      step();
      checks++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp || frame_done !== e_fd)
        $display("FAIL snapshot p=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b", p, an_n, e_an, seg_n, e_seg, dp_n, e_dp, frame_done, e_fd);
      else passed++;
    end
  endtask
  task automatic test_enable();
    dp_mask = 4'b0010;
    while (p % SD != 4) step();
    for (int i = 0; i < 2 * FR; i++) begin
      enable = !(i >= 1 && i < 11);
      step();
      checks++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp || frame_done !== e_fd)
        $display("FAIL enable p=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b", p, an_n, e_an, seg_n, e_seg, dp_n, e_dp, frame_done, e_fd);
      else passed++;
      checks++;
      if (dp_n !== (an_n != 4'b1101)) $display("FAIL dp_digit p=%0d dp=%b an=%b", p, dp_n, an_n);
      else passed++;
    end
    dp_mask = '0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 0) for (int j = 0; j < D; j++) bcd_in[j] = 4'($urandom_range(0, 15));
      if (i % 16 == 0) lz_blank = 1'($urandom);
      if (i % 5 == 0) dp_mask = D'($urandom);
      enable = $urandom_range(0, 7) != 0;
      step();
      checks++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp || frame_done !== e_fd)
        $display("FAIL random p=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b", p, an_n, e_an, seg_n, e_seg, dp_n, e_dp, frame_done, e_fd);
      else passed++;
    end
    enable = 1'b1;
  endtask
  task automatic test_async_reset();
    set_bcd(5, 6, 7, 8);
    lz_blank = 1'b0;
    while (p % SD != 5) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an_n !== '1 || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL async_reset an=%b seg=%b dp=%b fd=%b want 1111/1111111/1/0", an_n, seg_n, dp_n, frame_done);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FR + SD; i++) begin
      step();
      checks++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp || frame_done !== e_fd)
        $display("FAIL after_reset p=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b", p, an_n, e_an, seg_n, e_seg, dp_n, e_dp, frame_done, e_fd);
      else passed++;
    end
  endtask
  initial begin
    checks = 0;
    passed = 0;
    set_bcd(1, 2, 3, 4);
    model_reset();
    #12;
    test_reset();
    test_frames();
    test_slot_timing();
    test_lz();
    test_snapshot();
    test_enable();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
